controlador_memoria: RTL
========================

Name: controlador_memoria

Overview:
Load/store initiator that drives the single-port data memory bank (EscreveMemoria/LeMemoria/Endereco/DadoSalvo/DadoCarregado) on behalf of a requester.
- Accepts read or write burst commands over a valid/ready handshake.
- Streams write data in and read data out.
- Sequences the memory strobes with registered, glitch-free outputs so that the memory only ever sees stable address, data and strobes across a clock edge.

Parameters:
ADDR_W, 8, address width; must match the memory bank (256 words).
DATA_W, 8, word width.
LEN_W, 4, burst length field width; beats = cmd_len+1 (1..16).

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller accepts command this cycle.
cmd_write  input  1  1 = write burst, 0 = read burst.
cmd_addr  input  ADDR_W  start word address.
cmd_len  input  LEN_W  beats minus one.
wr_valid  input  1  write data beat present.
wr_ready  output  1  controller accepts write beat.
wr_data  input  DATA_W  write data beat.
rd_valid  output  1  read data beat valid; single-cycle pulse, no backpressure.
rd_data  output  DATA_W  read data beat.
rd_last  output  1  marks final beat of a read burst, qualified by rd_valid.
busy  output  1  high when state is not OCIOSO or a memory strobe is high.
EscreveMemoria  output  1  memory write strobe, registered.
LeMemoria  output  1  memory read strobe, registered.
Endereco  output  ADDR_W  memory address, registered.
DadoSalvo  output  DATA_W  memory write data, registered.
DadoCarregado  input  DATA_W  memory read data; valid by mid-cycle of a LeMemoria cycle.

Behaviour:
- Clocking and reset: one clock domain. reset_n is asynchronous and active-low. While reset_n=0:
  - state=OCIOSO;
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, busy=0, EscreveMemoria=0, LeMemoria=0;
  - Endereco=0, DadoSalvo=0, rd_data=0.
  - Reset mid-burst abandons the burst; no further strobes are issued.
- Output registration: all memory-side outputs change only on rising clock edges.
- State machine: OCIOSO, ESCRITA, LEITURA.
- OCIOSO:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge k: latch addr into the pointer and cmd_len into the countdown; go to ESCRITA if cmd_write=1, else LEITURA.
- ESCRITA:
  - wr_ready=1.
  - Each wr_valid&&wr_ready at edge j registers EscreveMemoria=1, Endereco=ptr, DadoSalvo=wr_data for cycle j+1; the memory commits at edge j+2.
  - Without a handshake, EscreveMemoria=0 the next cycle; wr_valid gaps are allowed.
  - ptr increments mod 2^ADDR_W (0xFF wraps to 0x00); count decrements.
  - After the beat where count==0, go to OCIOSO. EscreveMemoria for that final beat is still high during the first OCIOSO cycle.
- LEITURA:
  - Beginning at edge k+1, one beat is issued per cycle with no bubbles: LeMemoria=1, Endereco=ptr.
  - At the edge closing each issue cycle: rd_data<=DadoCarregado and rd_valid<=1, plus rd_last<=1 if it was the final beat.
  - Latency: accept at edge k -> first rd_valid during cycle k+2. An N-beat burst yields N consecutive rd_valid cycles.
  - After issuing the final beat, LeMemoria<=0 and go to OCIOSO. The last rd_valid appears during the first OCIOSO cycle.
- Back-to-back commands: a new command may be accepted in the OCIOSO cycle that drains the previous burst's final strobe or rd_valid.
  - A read issued after a write to the same address returns the new data (the write commits before the read's negedge capture).
- Exclusivity and qualification:
  - EscreveMemoria and LeMemoria are never high in the same cycle.
  - cmd_valid outside OCIOSO is ignored and is not queued.
  - wr_valid outside ESCRITA is ignored and wr_ready=0.
- Don't-cares: DadoSalvo holds its last value when EscreveMemoria=0. Endereco holds its last value when idle.

Test Plan:
1. Write addr 0x10, len 0, data 0xAB; then read 0x10, len 0 -> EscreveMemoria high exactly 1 cycle with Endereco=0x10, DadoSalvo=0xAB; read gives rd_valid one cycle, two cycles after accept, rd_data=0xAB, rd_last=1.
2. Write burst addr 0xFE, len 3, data 0x01,0x02,0x03,0x04 with a 2-cycle wr_valid gap after beat 2 -> mem[0xFE..0xFF,0x00,0x01]=1,2,3,4; EscreveMemoria high only on 4 cycles; return to OCIOSO after beat 4.
3. Read burst addr 0xF8, len 15, after preloading mem[i]=i -> 16 consecutive rd_valid with rd_data 0xF8..0xFF,0x00..0x07; rd_last only on the 16th; LeMemoria high exactly 16 cycles.
4. cmd_valid held high with a second command during a read burst -> second command accepted exactly once, in the first OCIOSO cycle; no overlap of strobes.
5. reset_n pulsed low asynchronously mid read burst (beat 5) -> all outputs 0 immediately; no further rd_valid; cmd_ready=1 one cycle after release.
6. Random command mix of 200 bursts against a reference memory model -> all read data match; assertion that EscreveMemoria&&LeMemoria never holds.

Source files
------------

// File: rtl/controlador_memoria.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : controlador_memoria
//  Description : Burst load/store initiator for a single-port data memory
//                bank, with registered strobes, address and write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module controlador_memoria #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              EscreveMemoria,
    output logic              LeMemoria,
    output logic [ADDR_W-1:0] Endereco,
    output logic [DATA_W-1:0] DadoSalvo,
    input  logic [DATA_W-1:0] DadoCarregado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESCRITA = 2'd1,
        LEITURA = 2'd2
    } estado_t;

    estado_t           state_q, state_d;
    logic              armed_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // armed_q keeps cmd_ready low until the first edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OCIOSO;
            armed_q    <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            re_q       <= re_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_valid_d = re_q;
        rd_last_d  = re_q && last_q;
        rd_data_d  = re_q ? DadoCarregado : rd_data_q;

        case (state_q)
            OCIOSO: begin
                if (cmd_valid && armed_q) begin
                    ptr_d   = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? ESCRITA : LEITURA;
                end
            end
            ESCRITA: begin
                if (wr_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = wr_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = OCIOSO;
                    end
                end
            end
            LEITURA: begin
                // Stay one extra cycle after the final issue so the last
                // rd_valid lands in the first idle cycle.
                if (re_q && last_q) begin
                    state_d = OCIOSO;
                end else begin
                    re_d   = 1'b1;
                    addr_d = ptr_q;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    last_d = (cnt_q == '0);
                end
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    assign cmd_ready      = armed_q && (state_q == OCIOSO);
    assign wr_ready       = (state_q == ESCRITA);
    assign busy           = (state_q != OCIOSO) || we_q || re_q;
    assign EscreveMemoria = we_q;
    assign LeMemoria      = re_q;
    assign Endereco       = addr_q;
    assign DadoSalvo      = wdata_q;
    assign rd_valid       = rd_valid_q;
    assign rd_last        = rd_last_q;
    assign rd_data        = rd_data_q;

endmodule
`default_nettype wire
